// File: rtl/result_packer_pkg.sv
// Shared types and helpers for the result bit packer.
// Contents: default word width, collect-side state enum, field-width helper.
package result_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  // Collect side: FILL gathers bits, FULL holds a complete word waiting for the slot.
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  // Bits needed to represent 0..width (length and ones-count fields).
  function automatic int unsigned clog2w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/result_packer_if.sv
// Bit-in / word-out bus of the result packer.
// Input side : in_valid, in_bit, in_ready, flush (single-cycle close request).
// Output side: out_valid, out_ready, out_data, out_len, out_ones.
// slave  = packer view, master = producer/consumer view.
interface result_packer_if #(
  parameter int unsigned WIDTH = result_pkg::DEF_WIDTH,
  parameter int unsigned CW    = result_pkg::clog2w(WIDTH)
);

  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_len;
  logic [CW-1:0]    out_ones;

  modport slave (
    input  in_valid, in_bit, flush, out_ready,
    output in_ready, out_valid, out_data, out_len, out_ones
  );

  modport master (
    output in_valid, in_bit, flush, out_ready,
    input  in_ready, out_valid, out_data, out_len, out_ones
  );

endinterface

// File: rtl/result_packer_out_slot.sv
// One-entry output register for packed words with a valid/ready handshake.
// Ports: clk, rst (sync, active-high); load_i + data_i/len_i/ones_i write the slot;
// ready_i is the consumer ready; load_ok_o (combinational) = slot may be written
// this cycle; valid_o/data_o/len_o/ones_o are the registered slot contents.
module result_out_slot #(
  parameter int unsigned WIDTH = result_pkg::DEF_WIDTH,
  parameter int unsigned CW    = result_pkg::clog2w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [CW-1:0]    len_i,
  input  logic [CW-1:0]    ones_i,
  input  logic             ready_i,
  output logic             load_ok_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    len_o,
  output logic [CW-1:0]    ones_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    len_q;
  logic [CW-1:0]    ones_q;

  // Empty slot, or the current word leaves on this edge.
  always_comb begin
    load_ok_o = !valid_q || ready_i;
  end

  // Slot register; a load on the handshake edge keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      len_q   <= '0;
      ones_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      len_q   <= len_i;
      ones_q  <= ones_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign len_o   = len_q;
  assign ones_o  = ones_q;

endmodule

// File: rtl/result_packer.sv
// Packs valid-qualified Result bits LSB first into WIDTH-bit words and presents
// each complete or flushed word with its length and population count.
// Ports: clk, rst (sync, active-high); bus_if (slave) carries the bit input
// handshake, flush, and the word output handshake. Collector plus output slot
// give full throughput while out_ready stays high.
module result_packer
  import result_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  result_packer_if.slave  bus_if
);

  localparam int unsigned CW = clog2w(WIDTH);

  state_e           state_q;
  logic             in_ready_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    ones_q;

  logic             accept_c;
  logic [WIDTH-1:0] word_c;
  logic [CW-1:0]    wcnt_c;
  logic [CW-1:0]    wones_c;
  logic             complete_c;
  logic             load_c;
  logic             load_ok_c;

  // Word as it stands after this cycle's accepted bit (equals the held word in FULL,
  // where nothing is accepted).
  always_comb begin
    accept_c   = bus_if.in_valid && in_ready_q;
    word_c     = sh_q | (WIDTH'(accept_c && bus_if.in_bit) << cnt_q);
    wcnt_c     = cnt_q + CW'(accept_c);
    wones_c    = ones_q + CW'(accept_c && bus_if.in_bit);
    complete_c = (state_q == FILL) &&
                 ((accept_c && (wcnt_c == CW'(WIDTH))) ||
                  (bus_if.flush && (wcnt_c != '0)));
    load_c     = (complete_c || (state_q == FULL)) && load_ok_c;
  end

  // Collect-side FSM with shift register and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      in_ready_q <= 1'b1;
      sh_q       <= '0;
      cnt_q      <= '0;
      ones_q     <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (complete_c && load_ok_c) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            ones_q <= '0;
          end else begin
            sh_q   <= word_c;
            cnt_q  <= wcnt_c;
            ones_q <= wones_c;
            if (complete_c) begin
              state_q    <= FULL;
              in_ready_q <= 1'b0;
            end
          end
        end
        FULL: begin
          if (load_ok_c) begin
            state_q    <= FILL;
            in_ready_q <= 1'b1;
            sh_q       <= '0;
            cnt_q      <= '0;
            ones_q     <= '0;
          end
        end
        default: begin
          state_q    <= FILL;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus_if.in_ready = in_ready_q;

  result_out_slot #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load_c),
    .data_i    (word_c),
    .len_i     (wcnt_c),
    .ones_i    (wones_c),
    .ready_i   (bus_if.out_ready),
    .load_ok_o (load_ok_c),
    .valid_o   (bus_if.out_valid),
    .data_o    (bus_if.out_data),
    .len_o     (bus_if.out_len),
    .ones_o    (bus_if.out_ones)
  );

endmodule

// File: doc/result_packer.md
Name: result_packer

Overview:
- Downstream consumer of the single-bit `Result` output of the combinational `child` logic.
- Collects one valid-qualified bit per accepted cycle into a WIDTH-bit word, LSB first.
- Presents each completed or flushed word on a valid/ready output, with a population count and a length.
- Double-buffered (shift register plus output slot), so full throughput holds while `out_ready` stays high.

Parameters:
- WIDTH, 8, bits per packed word; legal range 2..32.
- CW, $clog2(WIDTH+1), width of the length and ones-count fields; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  `in_bit` is valid this cycle.
- in_bit  in  1  sampled `Result` bit.
- in_ready  out  1  block accepts `in_bit`; a transfer occurs when in_valid && in_ready.
- flush  in  1  single-cycle request to close the current partial word.
- out_valid  out  1  output slot holds a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIDTH  packed bits; bit k is the k-th accepted bit; unused upper bits are 0.
- out_len  out  CW  number of valid bits in out_data (1..WIDTH).
- out_ones  out  CW  count of 1s in out_data.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: clears shift register, bit count, ones count and output slot.
  - in_ready=1, out_valid=0, out_data=0, out_len=0, out_ones=0.
  - Reset mid-word discards all collected bits. Reset while out_valid=1 drops the word, with no handshake.
- State machine for the collecting side:
  - FILL: in_ready=1. Each accepted bit is written at index cnt; cnt and ones increment.
    - If the bit accepted makes cnt reach WIDTH, the word becomes complete.
    - If flush is asserted with cnt>0 after this cycle's accepted bit (the bit is included), the word becomes complete with len=cnt.
    - flush with cnt==0 and no bit accepted is ignored.
  - FULL: a complete word waits for the output slot. in_ready=0. flush is ignored.
- Transfer of a complete word into the output slot:
  - Happens in the same edge that completed it if the slot is empty or out_ready=1 this cycle. State stays FILL with cnt=0 and the shift register cleared.
  - Otherwise the state becomes FULL.
  - In FULL, the word transfers on the first cycle with slot empty or out_valid && out_ready. The state then returns to FILL with cnt=0.
- Latency: out_valid rises the cycle after the completing bit or flush.
- Throughput: with out_ready held high, in_ready never deasserts.
- Output handshake:
  - out_data, out_len and out_ones are stable while out_valid && !out_ready.
  - out_valid drops after a handshake unless a new word loads on the same edge, in which case out_valid stays 1.
- Simultaneous events:
  - A handshake and a slot reload on the same edge are legal.
  - in_valid while in_ready=0 is not a transfer; the upstream holds in_bit.
- Width rules: ones ≤ len ≤ WIDTH. No wrap: cnt is cleared when a word completes.

Decomposition:
- Package `result_pkg`:
  - state enum {FILL, FULL};
  - function `clog2w(WIDTH)`;
  - localparam for default WIDTH.
- Sub-module `result_out_slot`: one-entry register holding data/len/ones with valid/ready. It reports load-permitted = !valid || ready. The top-level shift/count logic and FSM are in result_packer.

Test Plan:
- Full word: WIDTH=8, out_ready=1, bits 1,0,1,1,0,0,0,1 on consecutive cycles -> next cycle out_valid=1, out_data=8'h8D, out_len=8, out_ones=4. in_ready stays 1.
- Flush: bits 1,1,0, then flush alone -> out_data=8'h03, out_len=3, out_ones=2. flush on the next, empty cycle produces no word.
- Flush with a bit: 2 bits 1,0, then bit 1 with flush in the same cycle -> out_data=8'h05, out_len=3, out_ones=2.
- Backpressure: out_ready=0, 16 consecutive bits, all 1 -> word 1 (8'hFF) held stable. in_ready=0 after the 16th bit; the 17th bit is not taken. Raise out_ready -> 8'hFF handshake, second 8'hFF presented next cycle, in_ready=1 again.
- Streaming: out_ready=1, 24 continuous bits alternating 1,0 -> three words 8'h55, each out_ones=4. in_ready never 0.
- Reset mid-operation: 5 bits collected and out_valid=1 with out_ready=0, then rst for one cycle -> out_valid=0, in_ready=1. The next 8 bits form a fresh word with no leftover bits.
